timer: RTL and testbench

TIMER -- requirements
Module: timer

---
 rtl/timer_if.sv | 20 ++
 rtl/timer.sv | 120 ++++++++++++
 tb/tb_timer.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/timer_if.sv
// CPU-side bus of the timer block: address/enable/write/data plus T-cycle phase.
interface timer_if;
  logic [1:0]  t_cycle;
  logic [15:0] bus_addr;
  logic        bus_enable;
  logic        bus_write;
  logic [7:0]  bus_data_in;
  logic [7:0]  bus_data_out;
  logic        bus_selected;

  modport master (
    output t_cycle, bus_addr, bus_enable, bus_write, bus_data_in,
    input  bus_data_out, bus_selected
  );

  modport slave (
    input  t_cycle, bus_addr, bus_enable, bus_write, bus_data_in,
    output bus_data_out, bus_selected
  );
endinterface

// File: rtl/timer.sv
// DIV/TIMA/TMA/TAC timer: free-running divider, selectable falling-edge tick,
// TIMA overflow with a 4-clk delayed reload from TMA and a one-clk interrupt.
module timer (
  input  logic   clk,
  input  logic   reset,
  timer_if.slave bus,
  output logic   irq_timer
);

  typedef enum logic [1:0] {COUNT, OVF, RELOAD} state_t;

  state_t      state, state_next;
  logic [15:0] div_counter;
  logic [7:0]  tima, tima_next;
  logic [7:0]  tma;
  logic [2:0]  tac;
  logic [1:0]  ovf_cnt, ovf_cnt_next;
  logic        tick_prev, tick_in, tick_fall, sel_bit;
  logic        hit, wr_commit, wr_div, wr_tima, wr_tma, wr_tac;

  // 0xFF04..0xFF07 share the upper 14 address bits
  assign hit              = (bus.bus_addr[15:2] == 14'h3FC1);
  assign bus.bus_selected = bus.bus_enable & hit;
  assign wr_commit        = bus.bus_selected & bus.bus_write & (bus.t_cycle == 2'd3);
  assign wr_div           = wr_commit & (bus.bus_addr[1:0] == 2'd0);
  assign wr_tima          = wr_commit & (bus.bus_addr[1:0] == 2'd1);
  assign wr_tma           = wr_commit & (bus.bus_addr[1:0] == 2'd2);
  assign wr_tac           = wr_commit & (bus.bus_addr[1:0] == 2'd3);

  always_comb begin
    sel_bit = 1'b0;
    case (tac[1:0])
      2'd0: sel_bit = div_counter[9];
      2'd1: sel_bit = div_counter[3];
      2'd2: sel_bit = div_counter[5];
      2'd3: sel_bit = div_counter[7];
      default: sel_bit = 1'b0;
    endcase
  end

  assign tick_in   = sel_bit & tac[2];
  assign tick_fall = tick_prev & ~tick_in;

  always_comb begin
    bus.bus_data_out = 8'hFF;
    if (bus.bus_selected && !bus.bus_write) begin
      case (bus.bus_addr[1:0])
        2'd0: bus.bus_data_out = div_counter[15:8];
        2'd1: bus.bus_data_out = tima;
        2'd2: bus.bus_data_out = tma;
        2'd3: bus.bus_data_out = {5'b11111, tac};
        default: bus.bus_data_out = 8'hFF;
      endcase
    end
  end

  always_comb begin
    state_next   = state;
    tima_next    = tima;
    ovf_cnt_next = ovf_cnt;
    irq_timer    = (state == RELOAD);
    case (state)
      COUNT: begin
        if (wr_tima) begin
          tima_next = bus.bus_data_in;
        end else if (tick_fall) begin
          tima_next = tima + 8'd1;
          if (tima == 8'hFF) begin
            state_next   = OVF;
            ovf_cnt_next = '0;
          end
        end
      end
      OVF: begin
        ovf_cnt_next = ovf_cnt + 2'd1;
        if (wr_tima) begin
          tima_next    = bus.bus_data_in;
          state_next   = COUNT;
          ovf_cnt_next = '0;
        end else if (ovf_cnt == 2'd3) begin
          // reload lands on entry to RELOAD so TIMA reads TMA during the irq clk
          tima_next    = wr_tma ? bus.bus_data_in : tma;
          state_next   = RELOAD;
          ovf_cnt_next = '0;
        end else if (tick_fall) begin
          tima_next = tima + 8'd1;
        end
      end
      RELOAD: begin
        tima_next  = wr_tma ? bus.bus_data_in : tma;
        state_next = COUNT;
      end
      default: begin
        state_next   = COUNT;
        ovf_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_counter <= '0;
      tima        <= '0;
      tma         <= '0;
      tac         <= '0;
      tick_prev   <= 1'b0;
      state       <= COUNT;
      ovf_cnt     <= '0;
    end else begin
      div_counter <= wr_div ? '0 : div_counter + 16'd1;
      tick_prev   <= tick_in;
      tima        <= tima_next;
      state       <= state_next;
      ovf_cnt     <= ovf_cnt_next;
      if (wr_tma) tma <= bus.bus_data_in;
      if (wr_tac) tac <= bus.bus_data_in[2:0];
    end
  end

endmodule

// File: tb/tb_timer.sv
// Scoreboard bench for timer: reads push expectations, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_timer;

  logic clk = 1'b0;
  logic reset;
  logic irq_timer;

  timer_if bus_if ();

  timer dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus_if.slave),
    .irq_timer (irq_timer)
  );

  always #125 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] data;
    logic       sel;
    logic       irq;
  } exp_t;

  exp_t sb_q[$];
  logic rd_req = 1'b0;
  int   checks = 0;
  int   fails  = 0;
  int   irq_seen = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %02h, expected %02h", name, act, req);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (irq_timer === 1'b1) irq_seen++;
    if (rd_req) begin
      if (sb_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL scoreboard: DUT output sampled with no expectation queued");
      end else begin
        e = sb_q.pop_front();
        check({e.name, ".data"}, bus_if.bus_data_out, e.data);
        check({e.name, ".sel"}, {7'b0, bus_if.bus_selected}, {7'b0, e.sel});
        check({e.name, ".irq"}, {7'b0, irq_timer}, {7'b0, e.irq});
      end
    end
  end

  task automatic idle();
    bus_if.t_cycle     = 2'd0;
    bus_if.bus_addr    = 16'h0000;
    bus_if.bus_enable  = 1'b0;
    bus_if.bus_write   = 1'b0;
    bus_if.bus_data_in = 8'h00;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    rd_req = 1'b0;
    idle();
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d, input logic [1:0] tc = 2'd3);
    bus_if.t_cycle     = tc;
    bus_if.bus_addr    = a;
    bus_if.bus_enable  = 1'b1;
    bus_if.bus_write   = 1'b1;
    bus_if.bus_data_in = d;
    cyc();
  endtask

  task automatic rd(input string n, input logic [15:0] a, input logic [7:0] d,
                    input logic s = 1'b1, input logic i = 1'b0, input logic we = 1'b0);
    bus_if.t_cycle     = 2'd0;
    bus_if.bus_addr    = a;
    bus_if.bus_enable  = 1'b1;
    bus_if.bus_write   = we;
    bus_if.bus_data_in = 8'h77;
    sb_q.push_back('{name: n, data: d, sel: s, irq: i});
    rd_req = 1'b1;
    cyc();
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    reset = 1'b0;
    idle();
    cyc();

    // reset state, reads while reset held low
    rd("rst_div",  16'hFF04, 8'h00);
    rd("rst_tima", 16'hFF05, 8'h00);
    rd("rst_tma",  16'hFF06, 8'h00);
    rd("rst_tac",  16'hFF07, 8'hF8);
    reset = 1'b1;

    // DIV: 256 clks -> upper byte 1; any write clears it
    run(256);
    rd("div_256", 16'hFF04, 8'h01);
    wr(16'hFF04, 8'h55);
    rd("div_clr", 16'hFF04, 8'h00);

    // write-phase access returns FF; writes off t_cycle 3 do nothing; unmapped address
    rd("wr_phase_read", 16'hFF06, 8'hFF, 1'b1, 1'b0, 1'b1);
    wr(16'hFF06, 8'h3C, 2'd2);
    rd("tma_tc2_ignored", 16'hFF06, 8'h00);
    rd("unmapped_ff03", 16'hFF03, 8'hFF, 1'b0);

    // bit-3 tick: falls at DIV write + 17, then every 16 clks
    wr(16'hFF05, 8'h00);
    wr(16'hFF06, 8'h00);
    wr(16'hFF04, 8'h00);
    wr(16'hFF07, 8'h05);
    run(160);
    rd("tima_160", 16'hFF05, 8'h0A);
    rd("tac_05",   16'hFF07, 8'hFD);

    // overflow -> 4 clks of 00 -> reload AB with one irq clk
    wr(16'hFF04, 8'h00);
    wr(16'hFF06, 8'hAB);
    wr(16'hFF05, 8'hFF);
    run(14);
    rd("ovf_pre",  16'hFF05, 8'hFF);
    rd("ovf_0",    16'hFF05, 8'h00);
    rd("ovf_1",    16'hFF05, 8'h00);
    rd("ovf_2",    16'hFF05, 8'h00);
    rd("ovf_3",    16'hFF05, 8'h00);
    rd("reload",   16'hFF05, 8'hAB, 1'b1, 1'b1);
    rd("post_rld", 16'hFF05, 8'hAB);

    // TIMA write during OVF cancels reload and irq
    wr(16'hFF04, 8'h00);
    wr(16'hFF06, 8'hAB);
    wr(16'hFF05, 8'hFF);
    run(14);
    rd("cancel_pre", 16'hFF05, 8'hFF);
    rd("cancel_ovf", 16'hFF05, 8'h00);
    wr(16'hFF05, 8'h30);
    for (int k = 0; k < 5; k++) rd($sformatf("cancel_%0d", k), 16'hFF05, 8'h30);

    // falling edges forced by DIV write and TAC write
    wr(16'hFF04, 8'h00);
    wr(16'hFF05, 8'h10);
    run(8);
    rd("divwr_pre",  16'hFF05, 8'h10);
    wr(16'hFF04, 8'h00);
    rd("divwr_same", 16'hFF05, 8'h10);
    rd("divwr_inc",  16'hFF05, 8'h11);
    run(6);
    wr(16'hFF07, 8'h00);
    rd("tacwr_same", 16'hFF05, 8'h11);
    rd("tacwr_inc",  16'hFF05, 8'h12);
    rd("tacwr_hold", 16'hFF05, 8'h12);

    // reset during OVF aborts the reload
    wr(16'hFF07, 8'h05);
    wr(16'hFF04, 8'h00);
    wr(16'hFF06, 8'hAB);
    wr(16'hFF05, 8'hFF);
    run(14);
    rd("rstovf_pre", 16'hFF05, 8'hFF);
    rd("rstovf_0",   16'hFF05, 8'h00);
    reset = 1'b0;
    rd("rstovf_tima", 16'hFF05, 8'h00);
    rd("rstovf_tac",  16'hFF07, 8'hF8);
    rd("rstovf_tma",  16'hFF06, 8'h00);
    reset = 1'b1;
    for (int k = 0; k < 6; k++) rd($sformatf("post_rst_%0d", k), 16'hFF05, 8'h00);
    rd("unmapped_ff08", 16'hFF08, 8'hFF, 1'b0);

    run(2);
    check("irq_pulse_count", irq_seen[7:0], 8'd1);
    check("scoreboard_drain", sb_q.size(), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
